// File: rtl/alu_exec_unit_if.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_if
//
// Purpose:
//   Groups the two valid/ready channels of the execute-stage ALU into a
//   single bundle: the operation channel (opcode + operands) flowing into the
//   unit and the result channel (result + flags) flowing out of it.
//
// Parameters:
//   DATA_W       operand/result width in bits
//
// Signals:
//   in_valid_i   upstream holds a valid operation
//   in_ready_o   unit can accept an operation this cycle
//   alu_ctrl_i   4-bit operation code from the ALU control decoder
//   src1_i       operand A
//   src2_i       operand B
//   out_valid_o  result registers hold a valid result
//   out_ready_i  downstream accepts the result
//   result_o     result
//   zero_o       result_o == 0
//   overflow_o   signed add/sub overflow or multiply truncation
//   illegal_o    opcode not supported
//
// Modports:
//   master       the side that issues operations and consumes results
//   slave        the ALU execute unit itself
// ---------------------------------------------------------------------------
interface alu_exec_unit_if #(
    parameter int DATA_W = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        alu_ctrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              overflow_o;
    logic              illegal_o;

    modport master (
        output in_valid_i,
        output alu_ctrl_i,
        output src1_i,
        output src2_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  result_o,
        input  zero_o,
        input  overflow_o,
        input  illegal_o
    );

    modport slave (
        input  in_valid_i,
        input  alu_ctrl_i,
        input  src1_i,
        input  src2_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output result_o,
        output zero_o,
        output overflow_o,
        output illegal_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Purpose:
//   Execute-stage ALU. Takes the 4-bit ALU control code plus two operands
//   over a valid/ready handshake, evaluates the operation, registers the
//   result and flags, and offers them downstream over a second valid/ready
//   handshake. Single-cycle operations have a latency of one cycle and can
//   stream at one operation per cycle when downstream is always ready.
//
// Optional feature (compile-time macro ALU_MULT_EN):
//   When defined, opcode 1000 runs an unsigned shift-add multiply taking
//   DATA_W iterations, one per cycle, during which the unit stalls upstream.
//   When undefined, no multiply hardware is built and 1000 is illegal.
//
// Parameters:
//   DATA_W      operand/result width in bits (>= 4)
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous, active-high reset
//   bus         alu_exec_unit_if.slave: operation channel in
//               (in_valid_i/in_ready_o, alu_ctrl_i, src1_i, src2_i) and
//               result channel out (out_valid_o/out_ready_i, result_o,
//               zero_o, overflow_o, illegal_o)
//
// Opcodes:
//   0010 add   0110 sub   0000 and   0001 or   1100 nor   0111 slt
//   1000 mul (ALU_MULT_EN only); anything else is illegal (result 0).
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_exec_unit_if.slave bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_MULT_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
`endif

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              overflow;
        logic              illegal;
    } alu_out_t;

`ifdef ALU_MULT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MUL  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;
`endif

    // Two's-complement overflow on add: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

    // Overflow on A-B: operands differ in sign and the result sign left A's.
    function automatic logic sub_ovf(input logic sign_a, input logic sign_b,
                                     input logic sign_r);
        return (sign_a != sign_b) && (sign_r != sign_a);
    endfunction

    // Single-cycle operation set. slt uses a true signed compare rather than
    // the sign of A-B, so it stays correct when the subtraction overflows.
    function automatic alu_out_t alu_eval(input logic [3:0]               op,
                                          input logic signed [DATA_W-1:0] a,
                                          input logic signed [DATA_W-1:0] b);
        alu_out_t                 o;
        logic signed [DATA_W-1:0] sum;
        logic signed [DATA_W-1:0] diff;
        o    = '0;
        sum  = a + b;
        diff = a - b;
        case (op)
            OP_ADD: begin
                o.result   = sum;
                o.overflow = add_ovf(a[DATA_W-1], b[DATA_W-1], sum[DATA_W-1]);
            end
            OP_SUB: begin
                o.result   = diff;
                o.overflow = sub_ovf(a[DATA_W-1], b[DATA_W-1], diff[DATA_W-1]);
            end
            OP_AND:  o.result = a & b;
            OP_OR:   o.result = a | b;
            OP_NOR:  o.result = ~(a | b);
            OP_SLT:  o.result = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default: o.illegal = 1'b1;
        endcase
        return o;
    endfunction

    state_t state;
    state_t state_nxt;

    logic in_ready;
    logic accept;
    logic accept_single;
    logic accept_mul;

    logic signed [DATA_W-1:0] src1_s;
    logic signed [DATA_W-1:0] src2_s;
    alu_out_t                 alu_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] result_p1;
    logic              zero_p1;
    logic              ovf_p1;
    logic              ill_p1;

`ifdef ALU_MULT_EN
    logic [CNT_W-1:0]    cnt;
    logic                mul_done;
    logic [2*DATA_W-1:0] acc_p1;
    logic [2*DATA_W-1:0] mcand_p1;
    logic [DATA_W-1:0]   mplier_p1;
    logic [2*DATA_W-1:0] prod_nxt;
`endif

    // ---- stage p0: operand capture view and combinational evaluation ----
    assign src1_s = bus.src1_i;
    assign src2_s = bus.src2_i;
    assign alu_p0 = alu_eval(bus.alu_ctrl_i, src1_s, src2_s);

`ifdef ALU_MULT_EN
    // Last iteration is the cycle in MUL where the counter reaches DATA_W-1;
    // the product is captured straight from the adder on that edge.
    assign mul_done = (state == ST_MUL) && (cnt == CNT_LAST);
    assign prod_nxt = mplier_p1[0] ? (acc_p1 + mcand_p1) : acc_p1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        accept        = 1'b0;
        accept_mul    = 1'b0;
        accept_single = 1'b0;

        case (state)
            ST_IDLE: in_ready = 1'b1;
            // Ready follows the downstream ready so a result can be handed
            // off and replaced on the same edge.
            ST_HOLD: in_ready = bus.out_ready_i;
            default: in_ready = 1'b0;
        endcase
        if (rst_i) begin
            in_ready = 1'b0;
        end

        accept = bus.in_valid_i && in_ready;
`ifdef ALU_MULT_EN
        accept_mul = accept && (bus.alu_ctrl_i == OP_MUL);
`endif
        accept_single = accept && !accept_mul;

        case (state)
            ST_IDLE: begin
                if (accept_single) begin
                    state_nxt = ST_HOLD;
                end
`ifdef ALU_MULT_EN
                if (accept_mul) begin
                    state_nxt = ST_MUL;
                end
`endif
            end
            ST_HOLD: begin
                if (bus.out_ready_i) begin
                    state_nxt = ST_IDLE;
                end
                if (accept_single) begin
                    state_nxt = ST_HOLD;
                end
`ifdef ALU_MULT_EN
                if (accept_mul) begin
                    state_nxt = ST_MUL;
                end
`endif
            end
`ifdef ALU_MULT_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_HOLD;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- stage p1: result and flag registers ----
    // Result and flags are cleared by reset so a reset never leaves a stale
    // value visible on the outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            ovf_p1    <= 1'b0;
            ill_p1    <= 1'b0;
        end else if (accept_single) begin
            vld_p1    <= 1'b1;
            result_p1 <= alu_p0.result;
            zero_p1   <= (alu_p0.result == '0);
            ovf_p1    <= alu_p0.overflow;
            ill_p1    <= alu_p0.illegal;
`ifdef ALU_MULT_EN
        end else if (mul_done) begin
            vld_p1    <= 1'b1;
            result_p1 <= prod_nxt[DATA_W-1:0];
            zero_p1   <= (prod_nxt[DATA_W-1:0] == '0);
            ovf_p1    <= |prod_nxt[2*DATA_W-1:DATA_W];
            ill_p1    <= 1'b0;
`endif
        end else if (bus.out_ready_i) begin
            // Handoff with nothing new (or a multiply just started).
            vld_p1 <= 1'b0;
        end
    end

`ifdef ALU_MULT_EN
    // ---- stage p1: iterative multiply state ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (accept_mul) begin
            cnt <= '0;
        end else if (state == ST_MUL) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Multiplicand shifts left and multiplier right each iteration, so the
    // adder only ever looks at multiplier bit 0.
    always_ff @(posedge clk_i) begin
        if (accept_mul) begin
            acc_p1    <= '0;
            mcand_p1  <= {{DATA_W{1'b0}}, bus.src1_i};
            mplier_p1 <= bus.src2_i;
        end else if (state == ST_MUL) begin
            acc_p1    <= prod_nxt;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end
`endif

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = vld_p1;
    assign bus.result_o    = result_p1;
    assign bus.zero_o      = zero_p1;
    assign bus.overflow_o  = ovf_p1;
    assign bus.illegal_o   = ill_p1;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Scoreboard bench for alu_exec_unit. The driver pushes the expected
// response of every accepted operation into a queue; an independent monitor
// pops and compares each time a result is handed off downstream, and also
// checks that a stalled result stays stable. Expected values come from an
// arithmetic reference model using 64-bit integers.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   rand_ready = 1'b0;
    exp_t sb_q[$];

    logic [3:0]   ops [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                              4'b1100, 4'b0111, 4'b1000, 4'b0101};
    logic [W-1:0] specials [6] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0005};

    alu_exec_unit_if #(.DATA_W(W)) bus ();

    alu_exec_unit #(.DATA_W(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t         e;
        longint       sa;
        longint       sb;
        longint       r;
        logic [W-1:0] lo;
`ifdef ALU_MULT_EN
        logic [63:0]  p;
`endif
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'b0010: begin
                r = sa + sb; lo = r[31:0];
                e.res = lo; e.ovf = (r != longint'($signed(lo)));
            end
            4'b0110: begin
                r = sa - sb; lo = r[31:0];
                e.res = lo; e.ovf = (r != longint'($signed(lo)));
            end
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b1100: e.res = ~(a | b);
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin
`ifdef ALU_MULT_EN
                p = {32'd0, a} * {32'd0, b};
                e.res = p[31:0];
                e.ovf = (p[63:32] != 32'd0);
`else
                e.ill = 1'b1;
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = specials[$urandom_range(0, 5)];
            1: v = W'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Must be called 1 time unit after a rising edge; returns the same way.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int waits);
        bus.in_valid_i = 1'b1;
        bus.alu_ctrl_i = op;
        bus.src1_i     = a;
        bus.src2_i     = b;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready_o && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 300) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready_o stayed %0b, required 1", bus.in_ready_o);
        end else begin
            sb_q.push_back(model(op, a, b));
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.alu_ctrl_i = 4'($urandom);
        bus.src1_i     = $urandom;
        bus.src2_i     = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
        chk({tag, "_result"}, 64'(bus.result_o), 64'd0);
        chk({tag, "_zero"}, 64'(bus.zero_o), 64'd0);
        chk({tag, "_overflow"}, 64'(bus.overflow_o), 64'd0);
        chk({tag, "_illegal"}, 64'(bus.illegal_o), 64'd0);
    endtask

    // Called just after a falling edge: resets mid-operation and checks that
    // nothing from before the reset ever comes out.
    task automatic reset_abort(input string tag);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_all_zero(tag);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_after"}, 64'(bus.in_ready_o), 64'd1);
        chk({tag, "_valid_after"}, 64'(bus.out_valid_o), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_no_stale"}, 64'(bus.out_valid_o), 64'd0);
        end
    endtask

    // Monitor: handoff happens on the rising edge following a falling edge
    // where out_valid_o && out_ready_i, since inputs only change after rises.
    initial begin
        exp_t         e;
        bit           hold_pend;
        logic [W-1:0] hold_res;
        logic [2:0]   hold_flags;
        hold_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_valid", 64'(bus.out_valid_o), 64'd1);
                    chk("hold_result", 64'(bus.result_o), 64'(hold_res));
                    chk("hold_flags", 64'({bus.zero_o, bus.overflow_o, bus.illegal_o}),
                        64'(hold_flags));
                end
                hold_pend = 1'b0;
                if (bus.out_valid_o && !bus.out_ready_i) begin
                    hold_pend  = 1'b1;
                    hold_res   = bus.result_o;
                    hold_flags = {bus.zero_o, bus.overflow_o, bus.illegal_o};
                end
                if (bus.out_valid_o && bus.out_ready_i) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: result 0x%0h with no operation outstanding",
                                 bus.result_o);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_result", 64'(bus.result_o), 64'(e.res));
                        chk("sb_zero", 64'(bus.zero_o), 64'(e.zero));
                        chk("sb_overflow", 64'(bus.overflow_o), 64'(e.ovf));
                        chk("sb_illegal", 64'(bus.illegal_o), 64'(e.ill));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int busy_bad;
        int k;
        logic [3:0] op;
        bus.in_valid_i  = 1'b0;
        bus.alu_ctrl_i  = 4'd0;
        bus.src1_i      = '0;
        bus.src2_i      = '0;
        bus.out_ready_i = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        sync();
        rst = 1'b0;

        // Add with signed overflow, latency 1
        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, w);
        @(negedge clk);
        chk("add_lat1_valid", 64'(bus.out_valid_o), 64'd1);
        chk("add_result", 64'(bus.result_o), 64'h8000_0000);
        chk("add_overflow", 64'(bus.overflow_o), 64'd1);
        chk("add_zero", 64'(bus.zero_o), 64'd0);

        // sub then slt back-to-back
        sync();
        issue(4'b0110, 32'd5, 32'd5, w);
        chk("b2b_first_ready", 64'(w), 64'd0);
        issue(4'b0111, 32'h8000_0000, 32'h0000_0001, w);
        chk("b2b_second_ready", 64'(w), 64'd0);
        @(negedge clk);
        chk("slt_valid", 64'(bus.out_valid_o), 64'd1);
        chk("slt_result", 64'(bus.result_o), 64'd1);
        chk("slt_overflow", 64'(bus.overflow_o), 64'd0);
        chk("slt_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Backpressure on nor
        sync();
        bus.out_ready_i = 1'b0;
        issue(4'b1100, 32'h0F0F_0F0F, 32'hF0F0_F0F0, w);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(bus.out_valid_o), 64'd1);
            chk("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            chk("bp_result", 64'(bus.result_o), 64'd0);
            bus.src1_i = $urandom;
            bus.src2_i = $urandom;
        end
        sync();
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(bus.out_valid_o), 64'd1);
        sync();
        @(negedge clk);
        chk("bp_handoff_done", 64'(bus.out_valid_o), 64'd0);

        // Illegal opcode
        sync();
        issue(4'b0101, 32'd3, 32'd4, w);
        @(negedge clk);
        chk("illegal_valid", 64'(bus.out_valid_o), 64'd1);
        chk("illegal_flag", 64'(bus.illegal_o), 64'd1);
        chk("illegal_result", 64'(bus.result_o), 64'd0);
        chk("illegal_overflow", 64'(bus.overflow_o), 64'd0);
`ifndef ALU_MULT_EN
        sync();
        issue(4'b1000, 32'd3, 32'd4, w);
        @(negedge clk);
        chk("nomul_valid", 64'(bus.out_valid_o), 64'd1);
        chk("nomul_illegal", 64'(bus.illegal_o), 64'd1);
        chk("nomul_result", 64'(bus.result_o), 64'd0);
`else
        // Multiply timing and truncation flag
        sync();
        issue(4'b1000, 32'h0001_0000, 32'h0001_0003, w);
        busy_bad = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (bus.in_ready_o || bus.out_valid_o) busy_bad++;
        end
        chk("mul_busy_cycles", 64'(busy_bad), 64'd0);
        @(negedge clk);
        chk("mul_lat_valid", 64'(bus.out_valid_o), 64'd1);
        chk("mul_result", 64'(bus.result_o), 64'h0003_0000);
        chk("mul_overflow", 64'(bus.overflow_o), 64'd1);

        // Reset in the middle of a multiply
        sync();
        issue(4'b1000, 32'd5, 32'd7, w);
        repeat (10) @(negedge clk);
        reset_abort("mulrst");
`endif

        // Reset while a result is held under backpressure
        sync();
        bus.out_ready_i = 1'b0;
        issue(4'b0010, 32'h1234_5678, 32'd1, w);
        @(negedge clk);
        reset_abort("holdrst");
        sync();
        issue(4'b0010, 32'd2, 32'd2, w);
        @(negedge clk);
        chk("post_reset_add", 64'(bus.result_o), 64'd4);

        // Randomized traffic with random downstream stalls
        sync();
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 9);
            op = (k < 8) ? ops[k] : 4'($urandom);
            issue(op, pick_operand(), pick_operand(), w);
            repeat ($urandom_range(0, 2)) sync();
        end
        rand_ready = 1'b0;
        sync();
        bus.out_ready_i = 1'b1;
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        sync();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU datapath. It is the consumer of the 4-bit ALU control code produced by the ALU control decoder.
- Accepts an operation code plus two operands over a valid/ready handshake. It registers the result and flags and presents them downstream over a second valid/ready handshake.
- With the optional multiply feature enabled, it runs an iterative multi-cycle multiply and stalls the upstream pipeline while busy.

Parameters:
- DATA_W, 32, operand/result width in bits (≥ 4).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  upstream holds a valid operation.
- in_ready_o  out  1  unit can accept this cycle.
- alu_ctrl_i  in  4  operation code.
- src1_i  in  DATA_W  operand A.
- src2_i  in  DATA_W  operand B.
- out_valid_o  out  1  result registers hold a valid result.
- out_ready_i  in  1  downstream accepts the result.
- result_o  out  DATA_W  result.
- zero_o  out  1  result_o == 0.
- overflow_o  out  1  signed overflow (add/sub) or product truncation (mul).
- illegal_o  out  1  opcode not supported.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - out_valid_o, result_o, zero_o, overflow_o, illegal_o all clear to 0.
  - in_ready_o is forced to 0 while rst_i = 1.
  - Reset asserted mid-multiply aborts the operation; no result is ever emitted for it.
- Opcodes:
  - 0010 add: A+B.
  - 0110 sub: A−B.
  - 0000 and: A&B.
  - 0001 or: A|B.
  - 1100 nor: ~(A|B).
  - 0111 slt: 1 if signed A < signed B, else 0. Must be correct even when A−B overflows.
  - 1000 mul: only with the optional feature.
  - Any other code: result 0, illegal_o = 1, overflow_o = 0. The op still completes as a normal single-cycle op.
- Overflow:
  - add: set when both operands have the same sign and the result sign differs.
  - sub: set when the operands have different signs and the result sign differs from A.
  - Always 0 for logic ops and slt.
- Arithmetic: result is the low DATA_W bits; wrap-around is permitted.
- Accept: a transfer occurs on a clock edge where in_valid_i && in_ready_o.
- State machine: IDLE, HOLD, MUL (MUL only with the feature).
  - IDLE:
    - in_ready_o = 1.
    - Single-cycle op accepted → HOLD, with result and flags registered at that edge. Latency 1: out_valid_o = 1 in the next cycle.
    - Mul accepted → MUL.
  - HOLD:
    - out_valid_o = 1; all outputs stay stable while out_ready_i = 0.
    - in_ready_o = out_ready_i. This combinational path allows back-to-back throughput of one op per cycle.
    - out_ready_i = 1 with no new accept → IDLE, out_valid_o = 0.
    - out_ready_i = 1 with a simultaneous single-cycle accept → stay in HOLD with the new result loaded.
    - out_ready_i = 1 with a simultaneous mul accept → MUL, out_valid_o = 0.
  - MUL:
    - in_ready_o = 0, out_valid_o = 0.
    - Performs DATA_W shift-add iterations, one per cycle, then → HOLD.
- Inputs are sampled only on the accept edge; operand changes at any other time have no effect.
- zero_o is computed from the registered result.

Optional Feature:
- ALU_MULT_EN defined:
  - Opcode 1000 performs an unsigned multiply A×B with an internal 2·DATA_W accumulator and a bit counter.
  - result_o = low DATA_W bits of the product.
  - overflow_o = 1 if the high DATA_W bits are nonzero.
  - out_valid_o rises DATA_W+1 cycles after the accept edge.
- ALU_MULT_EN undefined:
  - No MUL state, counter or accumulator is built.
  - Opcode 1000 is treated as illegal: result 0, illegal_o = 1, latency 1.

Test Plan:
- Reset, then add: 0x7FFFFFFF + 0x00000001 (0010) → next cycle out_valid_o = 1, result_o = 0x80000000, overflow_o = 1, zero_o = 0.
- sub then slt back-to-back with out_ready_i held at 1:
  - 5 − 5 (0110) → result 0, zero_o = 1.
  - slt 0x80000000 vs 0x00000001 (0111) → result 1, no overflow flag.
  - One result per cycle, in_ready_o stays 1 throughout.
- Backpressure: nor of 0x0F0F0F0F and 0xF0F0F0F0 (1100) with out_ready_i = 0 for 5 cycles → result_o = 0x00000000 held stable, in_ready_o = 0. Release → handoff on the first edge with out_ready_i = 1.
- Illegal code 0101 with A = 3, B = 4 → result 0, illegal_o = 1, latency 1. Without ALU_MULT_EN, opcode 1000 gives the same response.
- With ALU_MULT_EN, mul 0x00010000 × 0x00010003:
  - in_ready_o = 0 for 32 cycles.
  - out_valid_o rises at cycle 33 with result 0x00030000 and overflow_o = 1.
- Assert rst_i at cycle 10 of a multiply → all outputs 0 immediately. After release: in_ready_o = 1, no stale result is emitted, and a following add 2+2 returns 4.
